// File: rtl/piksel_paketleyici_pkg.sv
// Package for the pixel packer: default geometry, counter width, FSM state
// type and the word-forming helper shared by the packer.
package piksel_paketleyici_pkg;

`include "sabitler.vh"

   localparam int VARSAYILAN_GENISLIK  = `VARSAYILAN_RESIM_GENISLIK;
   localparam int VARSAYILAN_YUKSEKLIK = `VARSAYILAN_RESIM_YUKSEKLIK;
   localparam int SAYAC_GENISLIK       = 17;
   localparam int KELIME_GENISLIK      = 32;

   typedef enum logic {
      BOSTA = `DURUM_BOSTA,
      TOPLA = `DURUM_TOPLA
   } durum_t;

   // Lanes above the current index are already zero in the holding register
   // (it is cleared after every emitted word), so a short final word comes
   // out zero-padded without extra masking.
   function automatic logic [KELIME_GENISLIK-1:0] kelime_olustur(
      input logic [23:0] tutulan,
      input logic [1:0]  indeks,
      input logic [7:0]  yeni
   );
      logic [KELIME_GENISLIK-1:0] k;
      k = {8'h00, tutulan};
      case (indeks)
         2'd0:    k[7:0]   = yeni;
         2'd1:    k[15:8]  = yeni;
         2'd2:    k[23:16] = yeni;
         default: k[31:24] = yeni;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/piksel_paketleyici_fifo.sv
// paket_fifo: synchronous first-word-fall-through FIFO.
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   temizle_i       synchronous flush (pointers and count to zero)
//   yaz_i/yaz_veri_i   push request and data; accepted when not full or
//                      when a pop happens in the same cycle
//   oku_i           pop request; ignored when empty
//   oku_veri_o      head entry, zero while empty
//   dolu_o, bos_o   full / empty flags
//   doluluk_o       current occupancy
module paket_fifo #(
   parameter  int GENISLIK = 33,
   parameter  int DERINLIK = 16,
   localparam int ADRES_W  = $clog2(DERINLIK)
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                temizle_i,
   input  logic                yaz_i,
   input  logic [GENISLIK-1:0] yaz_veri_i,
   input  logic                oku_i,
   output logic [GENISLIK-1:0] oku_veri_o,
   output logic                dolu_o,
   output logic                bos_o,
   output logic [ADRES_W:0]    doluluk_o
);

   logic [GENISLIK-1:0] bellek [DERINLIK];
   logic [ADRES_W-1:0]  yaz_ptr;
   logic [ADRES_W-1:0]  oku_ptr;
   logic [ADRES_W:0]    sayac;
   logic                yaz_etkin;
   logic                oku_etkin;

   assign bos_o     = (sayac == '0);
   assign dolu_o    = (sayac == (ADRES_W+1)'(DERINLIK));
   assign doluluk_o = sayac;

   // A pop frees the slot the push needs, so push-while-full is allowed then.
   assign oku_etkin = oku_i & ~bos_o;
   assign yaz_etkin = yaz_i & (~dolu_o | oku_etkin);

   assign oku_veri_o = bos_o ? '0 : bellek[oku_ptr];

   always_ff @(posedge clk_i) begin
      if (yaz_etkin) begin
         bellek[yaz_ptr] <= yaz_veri_i;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         yaz_ptr <= '0;
         oku_ptr <= '0;
         sayac   <= '0;
      end else if (temizle_i) begin
         yaz_ptr <= '0;
         oku_ptr <= '0;
         sayac   <= '0;
      end else begin
         if (yaz_etkin) begin
            yaz_ptr <= yaz_ptr + 1'b1;
         end
         if (oku_etkin) begin
            oku_ptr <= oku_ptr + 1'b1;
         end
         case ({yaz_etkin, oku_etkin})
            2'b10:   sayac <= sayac + 1'b1;
            2'b01:   sayac <= sayac - 1'b1;
            default: sayac <= sayac;
         endcase
      end
   end

endmodule

// File: rtl/sabitler.vh
// Shared constants for the pixel packer: default image geometry and the
// FSM state encodings. Included by piksel_paketleyici_pkg only.
`ifndef SABITLER_VH
`define SABITLER_VH

`define VARSAYILAN_RESIM_GENISLIK  320
`define VARSAYILAN_RESIM_YUKSEKLIK 240

`define DURUM_BOSTA 1'b0
`define DURUM_TOPLA 1'b1

`endif

// File: rtl/piksel_paketleyici.sv
// piksel_paketleyici: packs the 8-bit convolution result stream into 32-bit
// words (earliest pixel in [7:0]), queues them in a FWFT FIFO and presents
// them on a valid/ready port with an end-of-frame flag.
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   temizle_i            synchronous flush; wins over a pixel in the same cycle
//   veri_etkin_i, veri_i pixel stream, cannot be stalled
//   cikis_gecerli_o, cikis_veri_o, cikis_son_o, cikis_hazir_i   word port
//   cerceve_bitti_o      pulse when the frame's last word transfers
//   tasma_o              sticky, a word was dropped on a full FIFO
//   doluluk_o            FIFO occupancy
//   saglama_o            frame checksum; only live when PIKSEL_SAGLAMA_EN is
//                        defined, otherwise constant zero
//
// state | meaning
// BOSTA | no pixel of a frame seen yet, counters at zero
// TOPLA | collecting pixels of the current frame
module piksel_paketleyici
   import piksel_paketleyici_pkg::*;
#(
   parameter  int RESIM_GENISLIK  = VARSAYILAN_GENISLIK,
   parameter  int RESIM_YUKSEKLIK = VARSAYILAN_YUKSEKLIK,
   parameter  int FIFO_DERINLIK   = 16,
   localparam int DOLULUK_W       = $clog2(FIFO_DERINLIK) + 1
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 temizle_i,
   input  logic                 veri_etkin_i,
   input  logic [7:0]           veri_i,
   output logic                 cikis_gecerli_o,
   output logic [31:0]          cikis_veri_o,
   output logic                 cikis_son_o,
   input  logic                 cikis_hazir_i,
   output logic                 cerceve_bitti_o,
   output logic                 tasma_o,
   output logic [DOLULUK_W-1:0] doluluk_o,
   output logic [15:0]          saglama_o
);

   localparam logic [SAYAC_GENISLIK-1:0] SON_INDEKS =
      SAYAC_GENISLIK'(RESIM_GENISLIK * RESIM_YUKSEKLIK - 1);

   durum_t                      durum;
   logic [1:0]                  bayt_idx;
   logic [23:0]                 tutulan;
   logic [SAYAC_GENISLIK-1:0]   piksel_sayac;
   logic                        kabul;
   logic                        son_piksel;
   logic                        yaz;
   logic                        oku;
   logic                        fifo_dolu;
   logic                        fifo_bos;
   logic [KELIME_GENISLIK-1:0]  kelime;
   logic [KELIME_GENISLIK:0]    fifo_giris;
   logic [KELIME_GENISLIK:0]    fifo_cikis;

   assign kabul      = veri_etkin_i & ~temizle_i;
   assign son_piksel = (piksel_sayac == SON_INDEKS);
   assign yaz        = kabul & ((bayt_idx == 2'd3) | son_piksel);
   assign kelime     = kelime_olustur(tutulan, bayt_idx, veri_i);
   assign fifo_giris = {son_piksel, kelime};
   assign oku        = cikis_hazir_i & ~fifo_bos;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         durum        <= BOSTA;
         bayt_idx     <= 2'd0;
         tutulan      <= 24'd0;
         piksel_sayac <= '0;
      end else if (temizle_i) begin
         durum        <= BOSTA;
         bayt_idx     <= 2'd0;
         tutulan      <= 24'd0;
         piksel_sayac <= '0;
      end else if (kabul) begin
         if (son_piksel) begin
            durum        <= BOSTA;
            bayt_idx     <= 2'd0;
            tutulan      <= 24'd0;
            piksel_sayac <= '0;
         end else begin
            durum        <= TOPLA;
            piksel_sayac <= (durum == BOSTA) ? SAYAC_GENISLIK'(1)
                                             : piksel_sayac + 1'b1;
            if (bayt_idx == 2'd3) begin
               bayt_idx <= 2'd0;
               tutulan  <= 24'd0;
            end else begin
               bayt_idx <= bayt_idx + 1'b1;
               case (bayt_idx)
                  2'd0:    tutulan[7:0]   <= veri_i;
                  2'd1:    tutulan[15:8]  <= veri_i;
                  default: tutulan[23:16] <= veri_i;
               endcase
            end
         end
      end
   end

   // A drop only happens when the FIFO is full and nothing leaves this cycle.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         tasma_o <= 1'b0;
      end else if (temizle_i) begin
         tasma_o <= 1'b0;
      end else if (yaz & fifo_dolu & ~oku) begin
         tasma_o <= 1'b1;
      end
   end

   paket_fifo #(
      .GENISLIK (KELIME_GENISLIK + 1),
      .DERINLIK (FIFO_DERINLIK)
   ) u_fifo (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .temizle_i  (temizle_i),
      .yaz_i      (yaz),
      .yaz_veri_i (fifo_giris),
      .oku_i      (oku),
      .oku_veri_o (fifo_cikis),
      .dolu_o     (fifo_dolu),
      .bos_o      (fifo_bos),
      .doluluk_o  (doluluk_o)
   );

   assign cikis_gecerli_o = ~fifo_bos;
   assign cikis_veri_o    = fifo_cikis[KELIME_GENISLIK-1:0];
   assign cikis_son_o     = fifo_cikis[KELIME_GENISLIK];
   // Driven from the output side, not the FSM: the packer may already be in
   // the next frame while the previous son word is still queued.
   assign cerceve_bitti_o = cikis_gecerli_o & cikis_hazir_i & cikis_son_o;

`ifdef PIKSEL_SAGLAMA_EN
   logic [15:0] akum;
   logic [15:0] akum_sonraki;
   logic [15:0] saglama;

   assign akum_sonraki = ((durum == BOSTA) ? 16'd0 : akum) + {8'd0, veri_i};

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         akum    <= 16'd0;
         saglama <= 16'd0;
      end else if (temizle_i) begin
         akum    <= 16'd0;
         saglama <= 16'd0;
      end else if (kabul) begin
         if (son_piksel) begin
            saglama <= akum_sonraki;
            akum    <= 16'd0;
         end else begin
            akum <= akum_sonraki;
         end
      end
   end

   assign saglama_o = saglama;
`else
   assign saglama_o = 16'd0;
`endif

endmodule
